rsp_merge_n: RTL

Parametrised N-channel response merger. It collects single-cycle response writes from several independent producer pipelines (for example the dispatcher's early-reject path and the or-tree completion path) into one response FIFO write port. Each channel has its own buffer, so a producer is never stalled. Channels are served round-robin and the merger honours the downstream FIFO's almost-full. This block replaces the fixed two-input response arbiter in the MMU top level.

---
 rtl/rsp_merge_n.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rsp_merge_n.sv
// N-channel response merger: each producer channel has its own circular buffer,
// and the buffers are drained round-robin into a single registered FIFO write port.
module rsp_merge_n #(
  parameter int N_CH          = 2,
  parameter int RSP_WIDTH     = 16,
  parameter int DEPTH         = 4,
  parameter int ALMOST_MARGIN = 1,
  localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_write_en,
  input  logic [N_CH*RSP_WIDTH-1:0] in_data,
  output logic [N_CH-1:0]          ch_almost_full,
  output logic [N_CH-1:0]          ch_overflow,
  output logic                     out_write_en,
  output logic [RSP_WIDTH-1:0]     out_data,
  output logic [CH_W-1:0]          out_ch_id,
  input  logic                     out_almost_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_TH   = CNT_W'(DEPTH - ALMOST_MARGIN);

  logic [CNT_W-1:0]     count_q  [N_CH];
  logic [CNT_W-1:0]     count_d  [N_CH];
  logic [PTR_W-1:0]     wr_ptr_q [N_CH];
  logic [PTR_W-1:0]     wr_ptr_d [N_CH];
  logic [PTR_W-1:0]     rd_ptr_q [N_CH];
  logic [PTR_W-1:0]     rd_ptr_d [N_CH];
  logic [RSP_WIDTH-1:0] mem_q    [N_CH][DEPTH];
  logic [RSP_WIDTH-1:0] mem_d    [N_CH][DEPTH];

  logic [N_CH-1:0]      ovf_q, ovf_d;
  logic [CH_W-1:0]      last_grant_q, last_grant_d;
  logic                 out_we_q, out_we_d;
  logic [RSP_WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]      out_ch_id_q, out_ch_id_d;

  logic                 pop;
  logic [CH_W-1:0]      grant;
  logic [CH_W-1:0]      cand;
  logic [N_CH-1:0]      pop_vec, push_vec;

  // Round-robin: scan from last_grant+1 and take the first non-empty channel.
  always_comb begin
    pop   = 1'b0;
    grant = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      cand = CH_W'((32'(last_grant_q) + k) % N_CH);
      if (!pop && !out_almost_full && (count_q[cand] != '0)) begin
        pop   = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    pop_vec  = '0;
    push_vec = '0;
    ovf_d    = ovf_q;
    mem_d    = mem_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      count_d[i]  = count_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      pop_vec[i]  = pop && (grant == CH_W'(i));
      // A pop in the same cycle frees a slot, so a full channel can still accept.
      push_vec[i] = in_write_en[i] && ((count_q[i] != DEPTH_C) || pop_vec[i]);
      if (in_write_en[i] && !push_vec[i]) begin
        ovf_d[i] = 1'b1;
      end
      if (push_vec[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_data[i*RSP_WIDTH +: RSP_WIDTH];
        wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
      end
      if (pop_vec[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      end
      count_d[i] = count_q[i] + CNT_W'(push_vec[i]) - CNT_W'(pop_vec[i]);
    end
  end

  always_comb begin
    out_we_d     = pop;
    out_data_d   = out_data_q;
    out_ch_id_d  = out_ch_id_q;
    last_grant_d = last_grant_q;
    if (pop) begin
      out_data_d   = mem_q[grant][rd_ptr_q[grant]];
      out_ch_id_d  = grant;
      last_grant_d = grant;
    end
  end

  always_comb begin
    ch_almost_full = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      ch_almost_full[i] = (count_q[i] >= AF_TH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        count_q[i]  <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      ovf_q        <= '0;
      last_grant_q <= CH_W'(N_CH - 1);
      out_we_q     <= 1'b0;
      out_data_q   <= '0;
      out_ch_id_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        count_q[i]  <= count_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
      ovf_q        <= ovf_d;
      last_grant_q <= last_grant_d;
      out_we_q     <= out_we_d;
      out_data_q   <= out_data_d;
      out_ch_id_q  <= out_ch_id_d;
    end
  end

  // Payload storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ch_overflow  = ovf_q;
  assign out_write_en = out_we_q;
  assign out_data     = out_data_q;
  assign out_ch_id    = out_ch_id_q;

endmodule
